// File: rtl/pmem_line_responder_if.sv
// Line-memory bus between the cache miss path, the responder and its SRAM.
//
// Handshake: the requester raises pmem_read or pmem_write together with a
// stable pmem_address/pmem_wdata and keeps it high until it sees the
// one-cycle pmem_resp pulse. It must drop the request in the cycle after
// pmem_resp unless it wants a new transaction to start immediately. The SRAM
// side is a plain strobe: every cycle with sram_en high is one access, and
// read data returns on sram_rdata the following cycle.
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         sram_en;
    logic         sram_we;
    logic [15:0]  sram_addr;
    logic [15:0]  sram_wdata;
    logic [15:0]  sram_rdata;

    // Environment side: the requester plus the SRAM.
    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, sram_rdata,
        input  pmem_rdata, pmem_resp, sram_en, sram_we, sram_addr, sram_wdata
    );

    // Responder side.
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, sram_rdata,
        output pmem_rdata, pmem_resp, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/pmem_line_responder.sv
// Moves one 128-bit line per request as eight 16-bit beats to or from a
// synchronous SRAM with one-cycle read latency, then pulses pmem_resp.
module pmem_line_responder #(
    parameter int unsigned ACCESS_DELAY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pmem_line_responder_if.slave   bus,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam bit         HAS_WAIT  = (ACCESS_DELAY != 0);
    localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(ACCESS_DELAY - 1) : 4'd0;

    state_t       state_q, state_d;
    logic [3:0]   wait_q, wait_d;
    logic [2:0]   beat_q, beat_d;
    logic [11:0]  line_q, line_d;
    logic [127:0] wdata_q, wdata_d;
    logic         rd_op_q, rd_op_d;
    logic [127:0] rdata_q;
    logic         cap_q;
    logic [2:0]   cap_beat_q;

    // Byte-offset bits of the address select nothing inside a line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.pmem_address[3:0];

    assign bus.pmem_rdata = rdata_q;
    assign state_o        = state_q;

    // Next-state, request latching and SRAM beat generation.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        beat_d         = beat_q;
        line_d         = line_q;
        wdata_d        = wdata_q;
        rd_op_d        = rd_op_q;
        bus.pmem_resp  = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = 16'd0;
        bus.sram_wdata = 16'd0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.pmem_read || bus.pmem_write) begin
                    // Read wins when both are raised; the write is dropped.
                    line_d  = bus.pmem_address[15:4];
                    wdata_d = bus.pmem_wdata;
                    rd_op_d = bus.pmem_read;
                    wait_d  = 4'd0;
                    beat_d  = 3'd0;
                    state_d = HAS_WAIT ? S_WAIT : S_XFER;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_XFER;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_XFER: begin
                bus.sram_en   = 1'b1;
                bus.sram_we   = !rd_op_q;
                bus.sram_addr = {line_q, beat_q, 1'b0};
                if (!rd_op_q) begin
                    bus.sram_wdata = wdata_q[{beat_q, 4'b0000} +: 16];
                end
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Lets the last read beat land before responding.
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.pmem_resp = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, counter and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            beat_q  <= 3'd0;
            line_q  <= 12'd0;
            wdata_q <= 128'd0;
            rd_op_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            rd_op_q <= rd_op_d;
        end
    end

    // Read-data capture: the word for beat k arrives one cycle after beat k.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= 1'b0;
            cap_beat_q <= 3'd0;
            rdata_q    <= 128'd0;
        end else begin
            cap_q      <= (state_q == S_XFER) && rd_op_q;
            cap_beat_q <= beat_q;
            if (cap_q) begin
                rdata_q[{cap_beat_q, 4'b0000} +: 16] <= bus.sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: one instance with ACCESS_DELAY=4 (sel 0)
// and one with ACCESS_DELAY=0 (sel 1), each backed by its own SRAM array.
module tb_pmem_line_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_line_responder_if bus_a ();
    pmem_line_responder_if bus_b ();
    logic [2:0] state_a, state_b;

    pmem_line_responder #(.ACCESS_DELAY(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .state_o(state_a)
    );
    pmem_line_responder #(.ACCESS_DELAY(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .state_o(state_b)
    );

    // SRAM arrays seen by the DUTs and the bench's own view of memory.
    logic [15:0] sram_mem [2][32768];
    logic [15:0] ref_mem  [2][32768];
    logic [15:0] rd_a, rd_b;

    always @(posedge clk) begin
        if (bus_a.sram_en) begin
            if (bus_a.sram_we) sram_mem[0][bus_a.sram_addr[15:1]] = bus_a.sram_wdata;
            else rd_a <= sram_mem[0][bus_a.sram_addr[15:1]];
        end
        if (bus_b.sram_en) begin
            if (bus_b.sram_we) sram_mem[1][bus_b.sram_addr[15:1]] = bus_b.sram_wdata;
            else rd_b <= sram_mem[1][bus_b.sram_addr[15:1]];
        end
    end
    assign bus_a.sram_rdata = rd_a;
    assign bus_b.sram_rdata = rd_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_hold [2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [127:0] wd);
        if (sel == 0) begin
            bus_a.pmem_read = rd; bus_a.pmem_write = wr;
            bus_a.pmem_address = a; bus_a.pmem_wdata = wd;
        end else begin
            bus_b.pmem_read = rd; bus_b.pmem_write = wr;
            bus_b.pmem_address = a; bus_b.pmem_wdata = wd;
        end
    endtask

    // {sram_en, sram_we, sram_addr, sram_wdata, pmem_resp}
    function automatic logic [34:0] bus_now(input int sel);
        if (sel == 0)
            return {bus_a.sram_en, bus_a.sram_we, bus_a.sram_addr, bus_a.sram_wdata, bus_a.pmem_resp};
        return {bus_b.sram_en, bus_b.sram_we, bus_b.sram_addr, bus_b.sram_wdata, bus_b.pmem_resp};
    endfunction

    function automatic logic [127:0] rdata_now(input int sel);
        return (sel == 0) ? bus_a.pmem_rdata : bus_b.pmem_rdata;
    endfunction

    function automatic int delay_of(input int sel);
        return (sel == 0) ? 4 : 0;
    endfunction

    // Expected bus in cycle n of a transaction accepted in cycle 0.
    function automatic logic [34:0] exp_bus(input int d, input int n, input logic rd,
                                            input logic wr, input logic [15:0] a,
                                            input logic [127:0] wd);
        logic        en, we;
        logic [15:0] ad, wdw;
        logic [2:0]  kb;
        en = 1'b0; we = 1'b0; ad = 16'd0; wdw = 16'd0;
        if (n >= d + 1 && n <= d + 8) begin
            kb  = 3'(n - d - 1);
            en  = 1'b1;
            we  = wr && !rd;
            ad  = {a[15:4], kb, 1'b0};
            wdw = we ? wd[{kb, 4'b0000} +: 16] : 16'd0;
        end
        return {en, we, ad, wdw, (n == d + 10)};
    endfunction

    function automatic logic [127:0] line_model(input int sel, input logic [15:0] a);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = ref_mem[sel][{a[15:4], 3'(k)}];
        return r;
    endfunction

    // Runs one transaction; entry/exit points are negedges. With b2b set
    // the request is left high so the next call starts in the following cycle.
    task automatic run_txn(input int sel, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [127:0] wd, input bit b2b,
                           output logic [127:0] got, output int resp_cyc);
        int d;
        logic [127:0] exp_line;
        d = delay_of(sel);
        @(negedge clk);
        check("idle_bus", 128'(bus_now(sel)), 128'd0);
        check("rdata_hold", rdata_now(sel), exp_hold[sel]);
        drive(sel, rd, wr, a, wd);
        exp_line = line_model(sel, a);
        for (int n = 1; n <= d + 10; n++) begin
            @(negedge clk);
            check($sformatf("bus_s%0d_c%0d", sel, n), 128'(bus_now(sel)),
                  128'(exp_bus(d, n, rd, wr, a, wd)));
        end
        resp_cyc = cyc;
        got = rdata_now(sel);
        if (rd) begin
            check("rdata_read", got, exp_line);
            exp_hold[sel] = exp_line;
        end else begin
            check("rdata_after_write", got, exp_hold[sel]);
            for (int k = 0; k < 8; k++) ref_mem[sel][{a[15:4], 3'(k)}] = wd[16*k +: 16];
        end
        if (!b2b) drive(sel, 1'b0, 1'b0, 16'd0, 128'd0);
    endtask

    typedef struct {
        int           sel;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [127:0] got, wd_r;
        int t1, t2, r, sel;
        logic rd, wr;
        logic [15:0] a;

        vecs[0] = '{0, 1'b1, 1'b0, 16'h1230, 128'd0,
                    128'hA007_A006_A005_A004_A003_A002_A001_A000};
        vecs[1] = '{1, 1'b0, 1'b1, 16'h4A5C,
                    128'h0007_0006_0005_0004_0003_0002_0001_0000, 128'd0};
        vecs[2] = '{1, 1'b1, 1'b0, 16'h4A5C, 128'd0,
                    128'h0007_0006_0005_0004_0003_0002_0001_0000};
        vecs[3] = '{0, 1'b1, 1'b1, 16'h1230, {8{16'hFFFF}},
                    128'hA007_A006_A005_A004_A003_A002_A001_A000};
        vecs[4] = '{0, 1'b1, 1'b0, 16'h1230, 128'd0,
                    128'hA007_A006_A005_A004_A003_A002_A001_A000};

        for (int i = 0; i < 32768; i++) begin
            sram_mem[0][i] = 16'(i * 7 + 3);
            sram_mem[1][i] = 16'(i * 5 + 1);
            ref_mem[0][i]  = sram_mem[0][i];
            ref_mem[1][i]  = sram_mem[1][i];
        end
        for (int k = 0; k < 8; k++) begin
            sram_mem[0][15'h0918 + 15'(k)] = 16'hA000 + 16'(k);
            ref_mem[0][15'h0918 + 15'(k)]  = 16'hA000 + 16'(k);
        end
        exp_hold[0] = 128'd0;
        exp_hold[1] = 128'd0;

        // Reset held with requests raised: everything stays quiet.
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h1230, {4{32'h5A5A_1234}});
        drive(1, 1'b1, 1'b1, 16'h4A50, {4{32'h5A5A_1234}});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_bus_a", 128'(bus_now(0)), 128'd0);
            check("rst_bus_b", 128'(bus_now(1)), 128'd0);
            check("rst_rdata_a", rdata_now(0), 128'd0);
            check("rst_rdata_b", rdata_now(1), 128'd0);
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'd0, 128'd0);
        drive(1, 1'b0, 1'b0, 16'd0, 128'd0);

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                    1'b0, got, t1);
            check($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
        end

        // Reset during beat 3 of a D=4 write: beats 0..3 land, no response.
        wd_r = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 16'h2340, wd_r);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("midrst_bus_c%0d", n), 128'(bus_now(0)),
                  128'(exp_bus(4, n, 1'b0, 1'b1, 16'h2340, wd_r)));
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'd0, 128'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_bus_in_rst", 128'(bus_now(0)), 128'd0);
            check("midrst_rdata_in_rst", rdata_now(0), 128'd0);
        end
        rst = 1'b0;
        exp_hold[0] = 128'd0;
        exp_hold[1] = 128'd0;
        for (int k = 0; k < 4; k++) ref_mem[0][{12'h234, 3'(k)}] = wd_r[16*k +: 16];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_quiet", 128'(bus_now(0)), 128'd0);
        end
        run_txn(0, 1'b1, 1'b0, 16'h2340, 128'd0, 1'b0, got, t1);

        // Back-to-back reads: responses D+11 cycles apart.
        run_txn(0, 1'b1, 1'b0, 16'h1230, 128'd0, 1'b1, got, t1);
        run_txn(0, 1'b1, 1'b0, 16'h1230, 128'd0, 1'b0, got, t2);
        check("b2b_gap_d4", 128'(t2 - t1), 128'd15);
        run_txn(1, 1'b1, 1'b0, 16'h4A5C, 128'd0, 1'b1, got, t1);
        run_txn(1, 1'b1, 1'b0, 16'h4A5C, 128'd0, 1'b0, got, t2);
        check("b2b_gap_d0", 128'(t2 - t1), 128'd11);

        // Random reads, writes and read+write collisions over a few lines.
        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            r = $urandom_range(0, 3);
            rd = (r == 0) || (r == 2);
            wr = (r == 1) || (r == 2) || (r == 3 && $urandom_range(0, 1) == 1);
            if (!rd && !wr) rd = 1'b1;
            a = {4'h7, 4'($urandom_range(0, 3)), 8'($urandom)};
            wd_r = {$urandom, $urandom, $urandom, $urandom};
            run_txn(sel, rd, wr, a, wd_r, 1'b0, got, t1);
            for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory responder for the 128-bit line interface that the cache drives. It accepts one line read or line write at a time on the `pmem_*` handshake. Each line is moved as eight 16-bit beats to or from a word-wide synchronous SRAM with one-cycle read latency, and the block raises a single-cycle `pmem_resp` on completion. It sits between the L1/L2 cache miss path and the backing store, and replaces the behavioural memory model in synthesizable builds.

## Interface
- `ACCESS_DELAY`, default 4: idle wait cycles inserted between accept and the first SRAM beat. Legal range 0..15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read`  in  1  line read request; held high by the requester until `pmem_resp`.
- `pmem_write`  in  1  line write request; held high by the requester until `pmem_resp`.
- `pmem_address`  in  16  byte address (`lc3b_word`); bits [3:0] ignored.
- `pmem_wdata`  in  128  write line (`mem_bus`); word k in bits [16k+15:16k].
- `pmem_rdata`  out  128  read line (`mem_bus`), same word mapping.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `sram_en`  out  1  SRAM access strobe, one beat per cycle.
- `sram_we`  out  1  write enable; meaningful only with `sram_en`.
- `sram_addr`  out  16  word-aligned byte address, bit 0 always 0.
- `sram_wdata`  out  16  write word.
- `sram_rdata`  in  16  read word, valid the cycle after `sram_en && !sram_we`.

## Operation
- **States:** IDLE, WAIT, XFER, DRAIN, RESP.
- **IDLE, request accept:**
  - A request is accepted when `pmem_read | pmem_write` is high.
  - On accept, latch `pmem_address[15:4]`, `pmem_wdata`, and the op. Read has priority if both are high; the write is then ignored.
  - Next state is WAIT if `ACCESS_DELAY` > 0, otherwise XFER.
- **WAIT:** a 4-bit counter counts `ACCESS_DELAY` cycles, then the FSM moves to XFER.
- **XFER:** a 3-bit beat counter runs 0..7 in consecutive cycles.
  - `sram_en` = 1 and `sram_addr` = {line[15:4], beat, 1'b0}.
  - On a write, `sram_we` = 1 and `sram_wdata` = latched word[beat].
  - After beat 7 the FSM moves to DRAIN.
- **Read capture:** the `sram_rdata` value arriving the cycle after beat k is written into `pmem_rdata[16k+15:16k]`. Beats 0..6 land during XFER; beat 7 lands during DRAIN.
- **DRAIN:** one cycle for both ops, with no SRAM access. Next state is RESP.
- **RESP:** `pmem_resp` = 1 for exactly one cycle, then the FSM returns to IDLE.
- **Input stability:** request, address, and wdata changes after accept are ignored.
- **`pmem_rdata` hold:** the value holds until the first capture of the next read. Writes never modify it.
- **Back-to-back:** a request seen in the IDLE cycle that follows RESP is accepted as a new transaction. The requester must have dropped its previous request by then.
- **Reset (`rst`):** takes effect at any state, including mid-XFER.
  - FSM goes to IDLE, counters clear, `pmem_rdata` = 0.
  - No further SRAM beats are issued. Beats already written are not undone.
- **Reset values:** `pmem_resp`=0, `pmem_rdata`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0.
- **Outside XFER:** `sram_en`=`sram_we`=0, and `sram_addr`/`sram_wdata` are driven 0.

## Timing
- **Cycle numbering:** cycle 0 is the IDLE cycle in which the request is sampled high.
- WAIT occupies cycles 1..D, where D = `ACCESS_DELAY`.
- XFER beats issue in cycles D+1..D+8.
- DRAIN is cycle D+9.
- `pmem_resp` is high in cycle D+10. Total latency from accept to response is D+10 cycles.
- For reads, `pmem_rdata` is complete and stable in the RESP cycle.
- For D=0 the WAIT state is skipped entirely; beat 0 issues in cycle 1 and `pmem_resp` rises in cycle 10.
- Sustained throughput: one line per D+11 cycles.

## Test plan
- **Reset:** assert `rst` for 2 cycles with requests high. All outputs stay 0 and no `sram_en` is asserted while `rst` is high.
- **Read, D=4:** preload words 0x1230..0x123E with 0xA000+k, then read 0x1230.
  - `sram_addr` steps 0x1230, 0x1232, … 0x123E in cycles 5..12.
  - `pmem_resp` pulses once in cycle 14.
  - `pmem_rdata` = 0xA007_A006_…_A000.
- **Write then read, D=0, address 0x4A5C:**
  - Write `pmem_wdata` = 0x0007_0006_…_0000. Eight `sram_we` beats at 0x4A50..0x4A5E; `pmem_resp` in cycle 10; `pmem_rdata` unchanged.
  - Follow-up read of the same line returns the written data.
- **Simultaneous `pmem_read`=`pmem_write`=1:** no `sram_we` is ever asserted; the transaction completes as a read with read data.
- **Reset mid-operation:** assert `rst` during XFER beat 3 of a write. Only beats 0..3 reach the SRAM, `pmem_resp` never pulses, and the next read is accepted normally from IDLE.
- **Back-to-back:** a read is re-asserted in the cycle after `pmem_resp`. A second transaction starts immediately and its `pmem_resp` arrives exactly D+11 cycles after the first.
